// File: rtl/hht_spmv_mac_if.sv
// hht_spmv_mac_if: operand-pair input stream and dot-product result stream
// of the SpMV multiply-accumulate back end. The MAC is the slave: it sinks
// operand pairs and sources results.
interface hht_spmv_mac_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int ROW_W  = 16
) ();
    // Operand pair stream from the CSR fetch front end
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mval;
    logic [DATA_W-1:0] in_vval;
    logic              in_last;
    logic              in_empty_row;

    // Result stream toward write-back
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_row;
    logic [ACC_W-1:0]  out_sum;
    logic              out_sat;

    modport slave (
        input  in_valid, in_mval, in_vval, in_last, in_empty_row,
        output in_ready,
        output out_valid, out_row, out_sum, out_sat,
        input  out_ready
    );

    modport master (
        output in_valid, in_mval, in_vval, in_last, in_empty_row,
        input  in_ready,
        input  out_valid, out_row, out_sum, out_sat,
        output out_ready
    );
endinterface

// File: rtl/hht_spmv_mac.sv
// hht_spmv_mac: row-wise multiply-accumulate back end of the HHT SpMV engine.
// S1 registers the operand product, S2 accumulates and forms the row result,
// which is then pushed into a small output FIFO. Input is only accepted when
// the FIFO has room for every row result already in flight.
// Optional feature macro: HHT_MAC_SAT_EN -- unsigned saturating product and
// sum with a sticky per-row out_sat flag. Undefined: wrap arithmetic, out_sat=0.
module hht_spmv_mac #(
    parameter int DATA_W     = 32,
    parameter int ACC_W      = 32,
    parameter int ROW_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [ROW_W-1:0] num_rows,
    output logic             done,
    hht_spmv_mac_if.slave    bus
);

    localparam int PW = 2 * DATA_W;           // full product width
    localparam int EW = PW + ACC_W;           // product zero-extended past ACC_W
    localparam int AW = $clog2(FIFO_DEPTH);   // FIFO pointer width
    localparam int CW = AW + 1;               // FIFO occupancy width
    localparam int BW = CW + 1;               // occupancy + in-flight reservations
    localparam int RW = ROW_W + ACC_W + 1;    // FIFO entry {row, sum, sat}

`ifdef HHT_MAC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Fit the full product into ACC_W bits; returns {clamped, value}.
    function automatic logic [ACC_W:0] fit_prod(input logic [PW-1:0] p);
        logic [EW-1:0] e;
        e = EW'(p);
        if (SAT_EN && (e[EW-1:ACC_W] != '0))
            return {1'b1, {ACC_W{1'b1}}};
        return {1'b0, e[ACC_W-1:0]};
    endfunction

    // Accumulate with wrap or clamp; returns {clamped, value}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SAT_EN && s[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    state_t            state;
    logic [ROW_W-1:0]  rows_q;
    logic [ROW_W-1:0]  row_idx;

    logic              vld_p1;
    logic              last_p1;
    logic              empty_p1;
    logic [PW-1:0]     prod_p1;

    logic [ACC_W-1:0]  acc_p2;
    logic              sticky_p2;
    logic              res_vld_p2;
    logic [ROW_W-1:0]  res_row_p2;
    logic [ACC_W-1:0]  res_sum_p2;
    logic              res_sat_p2;

    logic [RW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [RW-1:0]     head;

    logic              begin_pass;
    logic              in_fire;
    logic              push;
    logic              pop;
    logic [BW-1:0]     booked;
    logic [ACC_W:0]    prod_fit;
    logic [ACC_W:0]    sum_fit;
    logic              sat_now;

    assign begin_pass = start && ((state == S_IDLE) || (state == S_DONE));
    assign in_fire    = bus.in_valid && bus.in_ready;
    assign push       = res_vld_p2;
    assign pop        = bus.out_valid && bus.out_ready;
    assign cnt_next   = cnt + CW'(push) - CW'(pop);

    // Every row end already in S1/S2 holds a FIFO slot, so a push never overflows.
    assign booked       = BW'(cnt) + BW'(vld_p1 & last_p1) + BW'(res_vld_p2);
    assign bus.in_ready = (state == S_RUN) && (booked < BW'(FIFO_DEPTH));

    assign prod_fit = fit_prod(prod_p1);
    assign sum_fit  = sat_add(acc_p2, prod_fit[ACC_W-1:0]);
    assign sat_now  = sticky_p2 | prod_fit[ACC_W] | sum_fit[ACC_W];

    // Pass sequencing: IDLE/DONE wait for start, RUN until the final row is queued, DRAIN until empty.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state  <= S_IDLE;
            done   <= 1'b0;
            rows_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rows_q <= num_rows;
                        if (num_rows == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            done  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (push && (res_row_p2 == rows_q - ROW_W'(1)))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((cnt_next == '0) && !vld_p1 && !res_vld_p2) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- stage p1: operand product ----
    // S1 valid: one accepted pair per cycle.
    always_ff @(posedge Clk) begin
        if (!Rst) vld_p1 <= 1'b0;
        else      vld_p1 <= in_fire;
    end

    // S1 data: full-width product and row-end markers.
    always_ff @(posedge Clk) begin
        if (in_fire) begin
            prod_p1  <= PW'(bus.in_mval) * PW'(bus.in_vval);
            last_p1  <= bus.in_last | bus.in_empty_row;
            empty_p1 <= bus.in_empty_row;
        end
    end

    // ---- stage p2: accumulate and form row result ----
    // S2 control: accumulator, sticky flag and row counter, restarted on each pass.
    always_ff @(posedge Clk) begin
        if (!Rst || begin_pass) begin
            res_vld_p2 <= 1'b0;
            acc_p2     <= '0;
            sticky_p2  <= 1'b0;
            row_idx    <= '0;
        end else begin
            res_vld_p2 <= vld_p1 & last_p1;
            if (vld_p1) begin
                if (last_p1) begin
                    acc_p2    <= '0;
                    sticky_p2 <= 1'b0;
                    row_idx   <= row_idx + ROW_W'(1);
                end else begin
                    acc_p2    <= sum_fit[ACC_W-1:0];
                    sticky_p2 <= sat_now;
                end
            end
        end
    end

    // S2 result: an empty-row marker contributes nothing and reports no clamp.
    always_ff @(posedge Clk) begin
        if (vld_p1 && last_p1) begin
            res_row_p2 <= row_idx;
            res_sum_p2 <= empty_p1 ? '0 : sum_fit[ACC_W-1:0];
            res_sat_p2 <= empty_p1 ? 1'b0 : sat_now;
        end
    end

    // ---- output FIFO ----
    // FIFO pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt_next;
        end
    end

    // FIFO storage.
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= {res_row_p2, res_sum_p2, res_sat_p2};
    end

    // Head fields read as zero while empty, so reset clears them without clearing storage.
    assign head          = mem[rd_ptr];
    assign bus.out_valid = (cnt != '0);
    assign bus.out_row   = bus.out_valid ? head[RW-1 -: ROW_W] : '0;
    assign bus.out_sum   = bus.out_valid ? head[ACC_W:1] : '0;
    assign bus.out_sat   = bus.out_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_hht_spmv_mac.sv
// tb_hht_spmv_mac: directed scoreboard bench for hht_spmv_mac.
module tb_hht_spmv_mac;

    localparam int DATA_W     = 32;
    localparam int ACC_W      = 32;
    localparam int ROW_W      = 16;
    localparam int FIFO_DEPTH = 4;

`ifdef HHT_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [ACC_W-1:0] sum;
        logic             sat;
    } res_t;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic [ROW_W-1:0] num_rows = '0;
    logic             done;

    res_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_popped   = 0;
    int   n_accepted = 0;
    int   p0;

    hht_spmv_mac_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROW_W(ROW_W)) bus ();

    hht_spmv_mac #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ROW_W(ROW_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .Clk      (clk),
        .Rst      (rst_n),
        .start    (start),
        .num_rows (num_rows),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_res(input int row, input logic [ACC_W-1:0] sum, input logic sat);
        res_t e;
        e.row = ROW_W'(row);
        e.sum = sum;
        e.sat = sat;
        exp_q.push_back(e);
    endtask

    // Monitor: every result handed over is popped against the scoreboard.
    always @(negedge clk) begin : monitor
        res_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_popped++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got row %0d sum 0x%0h, required none",
                         bus.out_row, bus.out_sum);
            end else begin
                e = exp_q.pop_front();
                check("out_row", 64'(bus.out_row), 64'(e.row));
                check("out_sum", 64'(bus.out_sum), 64'(e.sum));
                check("out_sat", 64'(bus.out_sat), 64'(e.sat));
            end
        end
    end

    task automatic do_start(input int n);
        @(posedge clk);
        #1;
        start    = 1'b1;
        num_rows = ROW_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] v,
                        input logic last, input logic empty);
        bit ok;
        int t;
        ok = 1'b0;
        t  = 0;
        bus.in_valid     = 1'b1;
        bus.in_mval      = m;
        bus.in_vval      = v;
        bus.in_last      = last;
        bus.in_empty_row = empty;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            t++;
        end
        #1;
        bus.in_valid = 1'b0;
        if (ok) n_accepted++;
        else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 for 200 cycles, required 1");
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check(name, 64'(seen), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_row"},   64'(bus.out_row),   64'd0);
        check({tag, "_out_sum"},   64'(bus.out_sum),   64'd0);
        check({tag, "_out_sat"},   64'(bus.out_sat),   64'd0);
        check({tag, "_done"},      64'(done),          64'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test, required end within 10000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.in_valid     = 1'b0;
        bus.in_mval      = '0;
        bus.in_vval      = '0;
        bus.in_last      = 1'b0;
        bus.in_empty_row = 1'b0;
        bus.out_ready    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        // Zero rows: done the cycle after start
        do_start(0);
        check("zero_rows_done", 64'(done), 64'd1);
        check("zero_rows_in_ready", 64'(bus.in_ready), 64'd0);

        // Basic row: 31*82 + 32*8 = 2798, two cycles after the last pair
        do_start(1);
        check("start_clears_done", 64'(done), 64'd0);
        check("in_ready_after_start", 64'(bus.in_ready), 64'd1);
        expect_res(0, 32'd2798, 1'b0);
        send(32'd31, 32'd82, 1'b0, 1'b0);
        send(32'd32, 32'd8, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("latency_edge1_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("latency_edge2_out_valid", 64'(bus.out_valid), 64'd1);
        check("done_before_pop", 64'(done), 64'd0);
        @(negedge clk);
        check("done_after_pop", 64'(done), 64'd1);
        check("basic_sb_empty", 64'(exp_q.size()), 64'd0);

        // Empty rows around a single-pair row; marker operands must be ignored
        do_start(3);
        expect_res(0, 32'd0, 1'b0);
        expect_res(1, 32'd456, 1'b0);
        expect_res(2, 32'd0, 1'b0);
        send(32'hDEAD, 32'hBEEF, 1'b0, 1'b1);
        send(32'd8, 32'd57, 1'b1, 1'b0);
        send(32'h1234, 32'h5678, 1'b1, 1'b1);
        wait_done("empty_rows_done", 50);
        check("empty_rows_sb_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure: six one-pair rows with the consumer stalled
        bus.out_ready = 1'b0;
        p0 = n_popped;
        n_accepted = 0;
        do_start(6);
        for (int r = 0; r < 6; r++) expect_res(r, ACC_W'((r + 2) * (r + 3)), 1'b0);
        fork
            begin
                for (int r = 0; r < 6; r++)
                    send(DATA_W'(r + 2), DATA_W'(r + 3), 1'b1, 1'b0);
            end
            begin
                repeat (15) @(negedge clk);
                check("bp_accepted", 64'(n_accepted), 64'd4);
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                check("bp_out_valid", 64'(bus.out_valid), 64'd1);
                check("bp_no_pop_while_stalled", 64'(n_popped - p0), 64'd0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_done("bp_done", 100);
        check("bp_pops", 64'(n_popped - p0), 64'd6);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Overflow: 0xFFFFFFFF*2 then +1
        do_start(1);
        expect_res(0, 32'hFFFF_FFFF, SAT);
        send(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        send(32'd1, 32'd1, 1'b1, 1'b0);
        wait_done("overflow_done", 50);
        check("overflow_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-pass after two of five rows are buffered
        bus.out_ready = 1'b0;
        p0 = n_popped;
        do_start(5);
        send(32'd3, 32'd4, 1'b1, 1'b0);
        send(32'd5, 32'd6, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        repeat (5) @(negedge clk);
        check("midreset_no_output", 64'(n_popped - p0), 64'd0);
        do_start(1);
        expect_res(0, 32'd30, 1'b0);
        send(32'd5, 32'd6, 1'b1, 1'b0);
        wait_done("after_reset_done", 50);
        check("after_reset_sb_empty", 64'(exp_q.size()), 64'd0);

        // Stray start during RUN leaves the row count at 2
        do_start(2);
        expect_res(0, 32'd6, 1'b0);
        expect_res(1, 32'd12, 1'b0);
        send(32'd2, 32'd3, 1'b1, 1'b0);
        start    = 1'b1;
        num_rows = ROW_W'(7);
        @(posedge clk);
        #1;
        start = 1'b0;
        send(32'd3, 32'd4, 1'b1, 1'b0);
        wait_done("stray_start_done", 50);
        repeat (3) @(negedge clk);
        check("stray_start_in_ready", 64'(bus.in_ready), 64'd0);
        check("stray_start_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
